mips_cache_mem_arbiter: RTL and testbench

//  Memory-side stage behind the instruction and data caches. Services instruction-cache miss

---
 rtl/mips_cache_pkg.sv | 26 ++
 rtl/mips_cache_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mips_cache_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cache_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the MIPS instruction/data caches and
// the memory-side arbiter that services their misses over Avalon-MM.
package mips_cache_pkg;

  // Arbiter FSM states
  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RESP,
    WR_REQ
  } state_e;

  // Which cache owns the transaction in flight
  typedef enum logic {
    SRC_I,
    SRC_D
  } src_e;

  // Byte enables used for every read (whole word)
  localparam logic [3:0]  BE_FULL    = 4'b1111;
  // Clears the byte offset to form a word-aligned Avalon address
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mips_cache_mem_arbiter.sv
`timescale 1ns/1ps
// Memory-side stage behind the instruction and data caches. Arbitrates
// instruction fills, data fills and data write-throughs onto a single
// Avalon-MM master with one transaction in flight. Fixed priority:
// data write > data read > instruction read. RD_LATENCY must be 1..4.
module mips_cache_mem_arbiter
  import mips_cache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  // Instruction cache side
  input  logic                i_stall,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_data,
  output logic                i_data_valid,
  // Data cache side
  input  logic                d_rd_req,
  input  logic                d_wr_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_writedata,
  input  logic [DATA_W/8-1:0] d_byteenable,
  output logic [DATA_W-1:0]   d_data,
  output logic                d_data_valid,
  output logic                d_wr_done,
  // Avalon-MM master
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata
);

  localparam int         BE_W     = DATA_W / 8;
  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

  state_e              r_state;
  src_e                r_src;
  logic [1:0]          r_lat_cnt;
  logic [ADDR_W-1:0]   r_avm_address;
  logic                r_avm_read;
  logic                r_avm_write;
  logic [DATA_W-1:0]   r_avm_writedata;
  logic [BE_W-1:0]     r_avm_byteenable;
  logic [DATA_W-1:0]   r_i_data;
  logic                r_i_data_valid;
  logic [DATA_W-1:0]   r_d_data;
  logic                r_d_data_valid;
  logic                r_d_wr_done;

  logic [ADDR_W-1:0]   w_i_addr_al;
  logic [ADDR_W-1:0]   w_d_addr_al;

  assign w_i_addr_al = i_addr & ALIGN_MASK[ADDR_W-1:0];
  assign w_d_addr_al = d_addr & ALIGN_MASK[ADDR_W-1:0];

  // Arbitration FSM: issues one Avalon transaction at a time, waits out the
  // read latency, captures the word and returns it with a one-cycle pulse.
  always_ff @(posedge clk) begin
    // NOTE: state and outputs use non-blocking assignments so every branch
    // reads the pre-edge values, matching the flops that get built.
    if (rst) begin
      r_state          <= IDLE;
      r_src            <= SRC_I;
      r_lat_cnt        <= 2'd0;
      r_avm_address    <= '0;
      r_avm_read       <= 1'b0;
      r_avm_write      <= 1'b0;
      r_avm_writedata  <= '0;
      r_avm_byteenable <= '0;
      r_i_data         <= '0;
      r_i_data_valid   <= 1'b0;
      r_d_data         <= '0;
      r_d_data_valid   <= 1'b0;
      r_d_wr_done      <= 1'b0;
    end else begin
      // Response strobes are single-cycle unless a state raises them below
      r_i_data_valid <= 1'b0;
      r_d_data_valid <= 1'b0;
      r_d_wr_done    <= 1'b0;

      case (r_state)
        IDLE: begin
          if (d_wr_req) begin
            r_src            <= SRC_D;
            r_avm_address    <= w_d_addr_al;
            r_avm_writedata  <= d_writedata;
            r_avm_byteenable <= d_byteenable;
            r_avm_write      <= 1'b1;
            r_state          <= WR_REQ;
          end else if (d_rd_req) begin
            r_src            <= SRC_D;
            r_avm_address    <= w_d_addr_al;
            r_avm_byteenable <= '1;
            r_avm_read       <= 1'b1;
            r_state          <= RD_REQ;
          end else if (i_stall) begin
            r_src            <= SRC_I;
            r_avm_address    <= w_i_addr_al;
            r_avm_byteenable <= '1;
            r_avm_read       <= 1'b1;
            r_state          <= RD_REQ;
          end
        end

        // Hold the read stable until the slave takes it
        RD_REQ: begin
          if (!avm_waitrequest) begin
            r_avm_read <= 1'b0;
            r_lat_cnt  <= 2'd0;
            r_state    <= RD_WAIT;
          end
        end

        // Readdata is only meaningful on the last latency cycle
        RD_WAIT: begin
          if (r_lat_cnt == LAT_LAST) begin
            if (r_src == SRC_I) begin
              r_i_data       <= avm_readdata;
              r_i_data_valid <= 1'b1;
            end else begin
              r_d_data       <= avm_readdata;
              r_d_data_valid <= 1'b1;
            end
            r_state <= RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt + 2'd1;
          end
        end

        // Valid pulse is visible this cycle; the cache drops its request after it
        RESP: begin
          r_state <= IDLE;
        end

        // Write completes the moment the slave accepts it
        WR_REQ: begin
          if (!avm_waitrequest) begin
            r_avm_write <= 1'b0;
            r_d_wr_done <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign avm_address    = r_avm_address;
  assign avm_read       = r_avm_read;
  assign avm_write      = r_avm_write;
  assign avm_writedata  = r_avm_writedata;
  assign avm_byteenable = r_avm_byteenable;
  assign i_data         = r_i_data;
  assign i_data_valid   = r_i_data_valid;
  assign d_data         = r_d_data;
  assign d_data_valid   = r_d_data_valid;
  assign d_wr_done      = r_d_wr_done;

endmodule

// File: tb/tb_mips_cache_mem_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mips_cache_mem_arbiter. A behavioural Avalon slave
// (configurable wait states, RD_LATENCY=1) feeds the main instance; a second
// instance with RD_LATENCY=3 is driven by hand. Expected response strobes are
// queued when requests are raised and compared when the DUT pulses.
module tb_mips_cache_mem_arbiter;

  localparam logic [1:0] K_I = 2'd0;
  localparam logic [1:0] K_D = 2'd1;
  localparam logic [1:0] K_W = 2'd2;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance (RD_LATENCY = 1)
  logic        i_stall = 0;
  logic [31:0] i_addr = 0;
  logic [31:0] i_data;
  logic        i_data_valid;
  logic        d_rd_req = 0, d_wr_req = 0;
  logic [31:0] d_addr = 0, d_writedata = 0;
  logic [3:0]  d_byteenable = 0;
  logic [31:0] d_data;
  logic        d_data_valid, d_wr_done;
  logic [31:0] avm_address, avm_writedata;
  logic        avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 0;
  logic [31:0] avm_readdata = 0;

  // Second instance (RD_LATENCY = 3)
  logic        l3_i_stall = 0;
  logic [31:0] l3_i_addr = 0;
  logic [31:0] l3_i_data, l3_d_data;
  logic        l3_i_data_valid, l3_d_data_valid, l3_d_wr_done;
  logic [31:0] l3_avm_address, l3_avm_writedata;
  logic        l3_avm_read, l3_avm_write;
  logic [3:0]  l3_avm_byteenable;
  logic [31:0] l3_avm_readdata = 0;

  mips_cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .i_stall(i_stall), .i_addr(i_addr), .i_data(i_data), .i_data_valid(i_data_valid),
    .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_data(d_data), .d_data_valid(d_data_valid), .d_wr_done(d_wr_done),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
  );

  mips_cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .i_stall(l3_i_stall), .i_addr(l3_i_addr), .i_data(l3_i_data), .i_data_valid(l3_i_data_valid),
    .d_rd_req(1'b0), .d_wr_req(1'b0), .d_addr(32'h0),
    .d_writedata(32'h0), .d_byteenable(4'h0),
    .d_data(l3_d_data), .d_data_valid(l3_d_data_valid), .d_wr_done(l3_d_wr_done),
    .avm_address(l3_avm_address), .avm_read(l3_avm_read), .avm_write(l3_avm_write),
    .avm_writedata(l3_avm_writedata), .avm_byteenable(l3_avm_byteenable),
    .avm_waitrequest(1'b0), .avm_readdata(l3_avm_readdata)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave memory contents: a fixed boot word plus an address-derived pattern
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2402_0005;
    return {a[15:0] ^ 16'hA5A5, a[31:16]};
  endfunction

  // ---------------- Avalon slave model (main instance) ----------------
  int          ws_cfg = 0;
  int          ws_left = 0;
  bit          in_req = 0;
  bit          acc_pending = 0;
  logic [31:0] acc_addr = 0;
  bit          stall_prev = 0;
  logic [31:0] prev_addr = 0;
  logic [1:0]  prev_cmd = 0;
  int          n_rd_acc = 0, n_wr_acc = 0, n_stall = 0;
  logic [31:0] wr_last_addr = 0, wr_last_data = 0;
  logic [3:0]  wr_last_be = 0;

  always @(negedge clk) begin
    if (stall_prev) begin
      check("hold_addr", avm_address, prev_addr);
      check("hold_cmd", {30'd0, avm_read, avm_write}, {30'd0, prev_cmd});
    end
    avm_readdata = acc_pending ? rd_word(acc_addr) : $urandom();
    acc_pending  = 0;
    stall_prev   = 0;
    if (avm_read || avm_write) begin
      if (!in_req) begin
        in_req  = 1;
        ws_left = ws_cfg;
      end
      if (ws_left > 0) begin
        avm_waitrequest = 1'b1;
        ws_left--;
        n_stall++;
        stall_prev = 1;
        prev_addr  = avm_address;
        prev_cmd   = {avm_read, avm_write};
      end else begin
        avm_waitrequest = 1'b0;
        in_req = 0;
        if (avm_read) begin
          n_rd_acc++;
          check("rd_be", {28'd0, avm_byteenable}, 32'hF);
          acc_pending = 1;
          acc_addr    = avm_address;
        end else begin
          n_wr_acc++;
          wr_last_addr = avm_address;
          wr_last_data = avm_writedata;
          wr_last_be   = avm_byteenable;
        end
      end
    end else begin
      avm_waitrequest = 1'b0;
    end
  end

  // ---------------- Response monitor / scoreboard ----------------
  int n_ipulse = 0, n_dpulse = 0, n_wdone = 0;

  task automatic sb_pop(input logic [1:0] kind, input logic [31:0] data, input string tag);
    exp_t e;
    check({tag, "_expected"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_kind"}, {30'd0, kind}, {30'd0, e.kind});
      check({tag, "_data"}, data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (i_data_valid) begin n_ipulse++; sb_pop(K_I, i_data, "ivalid"); end
    if (d_data_valid) begin n_dpulse++; sb_pop(K_D, d_data, "dvalid"); end
    if (d_wr_done)    begin n_wdone++;  sb_pop(K_W, wr_last_data, "wdone"); end
  end

  // ---------------- Stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for a strobe; returns on the negedge of the pulse cycle
  task automatic wait_pulse(input int which, input string tag);
    bit seen = 0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      seen = (which == 0) ? i_data_valid : (which == 1) ? d_data_valid : d_wr_done;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int i0, d0, w0, r0, wa0, s0;

    rst = 1'b1;
    tick(3);
    // Reset state
    check("rst_cmd", {30'd0, avm_read, avm_write}, 32'd0);
    check("rst_addr", avm_address, 32'd0);
    check("rst_wdata", avm_writedata, 32'd0);
    check("rst_be", {28'd0, avm_byteenable}, 32'd0);
    check("rst_strobes", {29'd0, i_data_valid, d_data_valid, d_wr_done}, 32'd0);
    check("rst_idata", i_data, 32'd0);
    check("rst_ddata", d_data, 32'd0);
    rst = 1'b0;
    tick(1);

    // Instruction miss, minimum latency
    sb.push_back('{K_I, 32'h2402_0005});
    i_addr = 32'hBFC0_0003;
    i_stall = 1'b1;
    tick(1);
    check("t1_read", {31'd0, avm_read}, 32'd1);
    check("t1_addr", avm_address, 32'hBFC0_0000);
    check("t1_be", {28'd0, avm_byteenable}, 32'hF);
    tick(1);
    check("t1_read_drop", {31'd0, avm_read}, 32'd0);
    check("t1_early_valid", {31'd0, i_data_valid}, 32'd0);
    tick(1);
    check("t1_valid_t3", {31'd0, i_data_valid}, 32'd1);
    check("t1_data", i_data, 32'h2402_0005);
    i_stall = 1'b0;
    tick(1);
    check("t1_valid_width", {31'd0, i_data_valid}, 32'd0);
    check("t1_data_hold", i_data, 32'h2402_0005);
    tick(2);
    check("t1_no_reissue", {31'd0, avm_read}, 32'd0);

    // Data read with three wait-state cycles
    ws_cfg = 3;
    i0 = n_ipulse; d0 = n_dpulse; r0 = n_rd_acc; s0 = n_stall;
    d_addr = 32'h0000_200B;
    sb.push_back('{K_D, rd_word(32'h0000_2008)});
    d_rd_req = 1'b1;
    wait_pulse(1, "t2_dvalid");
    d_rd_req = 1'b0;
    tick(3);
    check("t2_dpulses", n_dpulse - d0, 32'd1);
    check("t2_ipulses", n_ipulse - i0, 32'd0);
    check("t2_rd_acc", n_rd_acc - r0, 32'd1);
    check("t2_stall_cycles", n_stall - s0, 32'd3);
    check("t2_ddata_hold", d_data, rd_word(32'h0000_2008));

    // Simultaneous instruction miss and data write: write wins
    ws_cfg = 0;
    i0 = n_ipulse; w0 = n_wdone; r0 = n_rd_acc; wa0 = n_wr_acc;
    sb.push_back('{K_W, 32'hDEAD_BEEF});
    sb.push_back('{K_I, rd_word(32'h0040_0010)});
    d_addr = 32'h0000_1004;
    d_byteenable = 4'b0011;
    d_writedata = 32'hDEAD_BEEF;
    d_wr_req = 1'b1;
    i_addr = 32'h0040_0010;
    i_stall = 1'b1;
    wait_pulse(2, "t3_wdone");
    d_wr_req = 1'b0;
    check("t3_wr_addr", wr_last_addr, 32'h0000_1004);
    check("t3_wr_be", {28'd0, wr_last_be}, 32'h3);
    check("t3_read_after_write", n_rd_acc - r0, 32'd0);
    wait_pulse(0, "t3_ivalid");
    i_stall = 1'b0;
    tick(3);
    check("t3_wdones", n_wdone - w0, 32'd1);
    check("t3_ipulses", n_ipulse - i0, 32'd1);
    check("t3_rd_acc", n_rd_acc - r0, 32'd1);
    check("t3_wr_acc", n_wr_acc - wa0, 32'd1);

    // Reset while waiting on read data
    i0 = n_ipulse;
    i_addr = 32'h0040_0020;
    i_stall = 1'b1;
    tick(1);
    check("t5_read", {31'd0, avm_read}, 32'd1);
    tick(1);
    rst = 1'b1;
    i_stall = 1'b0;
    tick(1);
    check("t5_rst_read", {31'd0, avm_read}, 32'd0);
    check("t5_rst_valid", {31'd0, i_data_valid}, 32'd0);
    check("t5_rst_idata", i_data, 32'd0);
    rst = 1'b0;
    tick(4);
    check("t5_no_pulse", n_ipulse - i0, 32'd0);
    check("t5_idle", {31'd0, avm_read}, 32'd0);
    sb.push_back('{K_I, rd_word(32'h0040_0024)});
    i_addr = 32'h0040_0024;
    i_stall = 1'b1;
    wait_pulse(0, "t5_fresh_ivalid");
    i_stall = 1'b0;
    tick(2);

    // Instruction miss withdrawn while the read is stalled
    ws_cfg = 2;
    i0 = n_ipulse; r0 = n_rd_acc;
    sb.push_back('{K_I, rd_word(32'h0040_0030)});
    i_addr = 32'h0040_0030;
    i_stall = 1'b1;
    tick(1);
    check("t6_read", {31'd0, avm_read}, 32'd1);
    i_stall = 1'b0;
    wait_pulse(0, "t6_ivalid");
    tick(3);
    check("t6_ipulses", n_ipulse - i0, 32'd1);
    check("t6_rd_acc", n_rd_acc - r0, 32'd1);
    check("t6_idle", {31'd0, avm_read}, 32'd0);
    ws_cfg = 0;

    // RD_LATENCY = 3 instance: only the third post-accept word is taken
    l3_i_addr = 32'h0000_0106;
    l3_i_stall = 1'b1;
    tick(1);
    check("l3_read", {31'd0, l3_avm_read}, 32'd1);
    check("l3_addr", l3_avm_address, 32'h0000_0104);
    tick(1);
    l3_avm_readdata = 32'hBAD0_0001;
    check("l3_read_drop", {31'd0, l3_avm_read}, 32'd0);
    tick(1);
    l3_avm_readdata = 32'hBAD0_0002;
    check("l3_no_early_valid", {31'd0, l3_i_data_valid}, 32'd0);
    tick(1);
    l3_avm_readdata = 32'h3C1D_0104;
    check("l3_no_valid_t4", {31'd0, l3_i_data_valid}, 32'd0);
    tick(1);
    l3_avm_readdata = 32'hBAD0_0003;
    check("l3_valid", {31'd0, l3_i_data_valid}, 32'd1);
    check("l3_data", l3_i_data, 32'h3C1D_0104);
    l3_i_stall = 1'b0;
    tick(1);
    check("l3_valid_width", {31'd0, l3_i_data_valid}, 32'd0);
    check("l3_data_hold", l3_i_data, 32'h3C1D_0104);

    tick(2);
    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
